// File: rtl/elevator_direction_sched.sv
// LOOK-style direction scheduler for one elevator car.
// Registered direction/target/status outputs with idle, nearest-first
// departure and a reversal hold window that late requests can cancel.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   queue_status    per-floor pending request bits
//   current_floor   car position (values >= NUM_FLOORS freeze the block)
//   next_up_ndown   committed direction, 1 = up
//   moving/idle/reversing  one-hot status of the scheduler
//   target_floor    nearest pending floor in the committed direction
module elevator_direction_sched #(
  parameter int NUM_FLOORS   = 8,
  parameter int FLOOR_W      = $clog2(NUM_FLOORS),
  parameter int REVERSE_HOLD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] queue_status,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic                  next_up_ndown,
  output logic                  moving,
  output logic                  idle,
  output logic                  reversing,
  output logic [FLOOR_W-1:0]    target_floor
);

  localparam int CNT_W =
    (REVERSE_HOLD > 1) ? $clog2(REVERSE_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    (REVERSE_HOLD > 0) ? CNT_W'(REVERSE_HOLD - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic               dir_q, dir_d;
  logic [FLOOR_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               idle_q, idle_d;
  logic               moving_q, moving_d;
  logic               rev_q, rev_d;

  logic               floor_ok;
  logic               above;
  logic               below;
  logic [FLOOR_W-1:0] near_up;
  logic [FLOOR_W-1:0] near_dn;
  logic [FLOOR_W:0]   cf_ext;
  logic [FLOOR_W:0]   dist_up;
  logic [FLOOR_W:0]   dist_dn;
  logic               up_closer;
  logic               ahead;
  logic               behind;

  assign cf_ext = {1'b0, current_floor};

  // Request decode. The downward scan leaves the lowest index above
  // the car in near_up; the upward scan leaves the highest index below.
  always_comb begin
    logic [FLOOR_W:0] idx;
    floor_ok = 1'b0;
    above    = 1'b0;
    below    = 1'b0;
    near_up  = '0;
    near_dn  = '0;
    idx      = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      idx = (FLOOR_W + 1)'(i);
      if (idx == cf_ext) floor_ok = 1'b1;
      if (queue_status[i] && (idx > cf_ext)) begin
        above   = 1'b1;
        near_up = idx[FLOOR_W-1:0];
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      idx = (FLOOR_W + 1)'(i);
      if (queue_status[i] && (idx < cf_ext)) begin
        below   = 1'b1;
        near_dn = idx[FLOOR_W-1:0];
      end
    end
  end

  assign dist_up   = {1'b0, near_up} - cf_ext;
  assign dist_dn   = cf_ext - {1'b0, near_dn};
  assign up_closer = (dist_up <= dist_dn);

  // Requests relative to the direction held during REVERSE_WAIT.
  assign ahead  = dir_q ? above : below;
  assign behind = dir_q ? below : above;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (floor_ok) begin
      unique case (state_q)
        S_IDLE: begin
          if (above && (!below || up_closer)) begin
            state_d = S_UP;
            dir_d   = 1'b1;
            tgt_d   = near_up;
          end else if (below) begin
            state_d = S_DOWN;
            dir_d   = 1'b0;
            tgt_d   = near_dn;
          end
        end
        S_UP: begin
          if (above) begin
            tgt_d = near_up;
          end else if (below) begin
            if (REVERSE_HOLD == 0) begin
              state_d = S_DOWN;
              dir_d   = 1'b0;
              tgt_d   = near_dn;
            end else begin
              state_d = S_WAIT;
              cnt_d   = HOLD_LOAD;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DOWN: begin
          if (below) begin
            tgt_d = near_dn;
          end else if (above) begin
            if (REVERSE_HOLD == 0) begin
              state_d = S_UP;
              dir_d   = 1'b1;
              tgt_d   = near_up;
            end else begin
              state_d = S_WAIT;
              cnt_d   = HOLD_LOAD;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          if (ahead) begin
            // A late request in the old direction cancels the turn.
            state_d = dir_q ? S_UP : S_DOWN;
            tgt_d   = dir_q ? near_up : near_dn;
          end else if (!behind) begin
            state_d = S_IDLE;
          end else if (cnt_q == '0) begin
            state_d = dir_q ? S_DOWN : S_UP;
            dir_d   = ~dir_q;
            tgt_d   = dir_q ? near_dn : near_up;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    idle_d   = (state_d == S_IDLE);
    moving_d = (state_d == S_UP) || (state_d == S_DOWN);
    rev_d    = (state_d == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dir_q    <= 1'b1;
      tgt_q    <= '0;
      cnt_q    <= '0;
      idle_q   <= 1'b1;
      moving_q <= 1'b0;
      rev_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      moving_q <= moving_d;
      rev_q    <= rev_d;
    end
  end

  assign next_up_ndown = dir_q;
  assign target_floor  = tgt_q;
  assign idle          = idle_q;
  assign moving        = moving_q;
  assign reversing     = rev_q;

endmodule

// File: doc/elevator_direction_sched.md
# elevator_direction_sched

Registered, parametrised direction scheduler for one elevator car using the LOOK algorithm. It watches a per-floor pending-request vector and the car's current floor, then commits a travel direction. It adds an idle state, nearest-request selection from idle, and a configurable reversal hold that lets late requests in the current direction cancel a turnaround. It sits between the request queue and the motion controller, in place of the combinational direction resolver.

## Interface
- NUM_FLOORS, 8, number of served floors (≥2)
- FLOOR_W, $clog2(NUM_FLOORS), floor index width
- REVERSE_HOLD, 2, cycles spent in REVERSE_WAIT before a reversal commits (0 = reverse immediately)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- queue_status  in  NUM_FLOORS  bit i = pending request at floor i
- current_floor  in  FLOOR_W  car's present floor
- next_up_ndown  out  1  committed direction, 1 = up, 0 = down
- moving  out  1  high in MOVE_UP / MOVE_DOWN
- idle  out  1  high in IDLE
- reversing  out  1  high in REVERSE_WAIT
- target_floor  out  FLOOR_W  nearest pending floor in the committed direction

## Operation
- Decode on the current inputs:
  - above = any queue_status bit at an index > current_floor.
  - below = any bit at an index < current_floor.
  - The current-floor bit counts as neither.
- Floor indices range from 0 to NUM_FLOORS-1.
- Nearest above = lowest set index > current_floor. Nearest below = highest set index < current_floor.
- Distances are computed in FLOOR_W+1 bits, with no wrap.
- IDLE:
  - above only → MOVE_UP.
  - below only → MOVE_DOWN.
  - Both → direction of the smaller distance; a tie goes up.
  - Neither → stay in IDLE.
- MOVE_UP:
  - above → stay, and target = nearest above.
  - else below → REVERSE_WAIT, or MOVE_DOWN directly if REVERSE_HOLD=0.
  - else → IDLE.
- MOVE_DOWN: mirror of MOVE_UP.
- REVERSE_WAIT:
  - On entry, a down-counter loads REVERSE_HOLD-1.
  - next_up_ndown and target_floor hold their old values.
  - Each cycle, a request in the old direction reappearing → return to the old MOVE state (cancel).
  - Else, if no request at all → IDLE.
  - Else, counter==0 → opposite MOVE state with the new target.
  - Else → decrement.
- IDLE holds the last next_up_ndown. target_floor holds its last value in IDLE.
- current_floor ≥ NUM_FLOORS (non-power-of-2 depth) is invalid: all state and outputs hold for that cycle.

## Timing
- All outputs are registered. A decision based on cycle-N inputs is visible after edge N+1 (1-cycle latency).
- Reset values (rst high at a clk edge): state=IDLE, idle=1, moving=0, reversing=0, next_up_ndown=1, target_floor=0, counter=0.
- rst overrides every transition, including mid-REVERSE_WAIT.
- Exactly one of idle/moving/reversing is high in every cycle.
- Reversal from MOVE_x with REVERSE_HOLD=H≥1:
  - reversing is high for H cycles.
  - next_up_ndown flips on the edge after the last REVERSE_WAIT cycle.
  - Total: H+1 cycles from the first cycle with no request ahead.
- Simultaneous above & below in MOVE_x: continue in the current direction; there is no reversal.
- A queue_status change and a current_floor change in the same cycle are both used by that cycle's decode.

## Test plan
- Reset:
  - Stimulus: assert rst for 2 cycles with arbitrary inputs.
  - Required: idle=1, moving=0, reversing=0, next_up_ndown=1, target_floor=0.
  - Stimulus: assert rst during REVERSE_WAIT.
  - Required: the same values one edge later.
- Idle departure:
  - Stimulus: floor 4, queue 8'b0000_0011.
  - Required, next cycle: moving=1, next_up_ndown=0, target_floor=1.
  - Stimulus: floor 4, queue 8'b1100_0000.
  - Required: next_up_ndown=1, target_floor=6.
- Nearest/tie from idle at floor 4:
  - Stimulus: queue 8'b1000_0001.
  - Required: up, target 7 (distance 3 < 4).
  - Stimulus: queue 8'b0100_0100.
  - Required: up, target 6 (tie → up).
- Reversal, REVERSE_HOLD=2:
  - Setup: MOVE_UP at floor 4, queue becomes 8'b0000_0011.
  - Required: reversing=1 for 2 cycles with next_up_ndown=1, then next_up_ndown=0, target_floor=1, moving=1.
  - Cancel: set bit 6 during the wait.
  - Required: returns to MOVE_UP, target_floor=6, next_up_ndown never drops.
- Stop and empty:
  - Stimulus: MOVE_DOWN, queue reduces to the current-floor bit only, or to all zeros.
  - Required: idle=1 next cycle, next_up_ndown retains 0.
  - Stimulus: REVERSE_WAIT with the queue cleared.
  - Required: IDLE next cycle.
- Range/params:
  - Stimulus: NUM_FLOORS=6 instance, current_floor=7.
  - Required: all outputs unchanged.
  - Stimulus: REVERSE_HOLD=0 instance.
  - Required: MOVE_UP→MOVE_DOWN in one edge, reversing never high.
